// File: rtl/mem_dump_ctrl.sv
// Post-halt dump sequencer: takes over the data-memory port and streams a word window, low byte first, to the UART.
// First o_tx_start 4 cycles after i_halt rises; each byte waits indefinitely for i_tx_done before the next start.
module mem_dump_ctrl #(
  parameter int                     DATA_LENGTH = 16,
  parameter int                     ADDR_LENGTH = 11,
  parameter logic [ADDR_LENGTH-1:0] BASE_ADDR   = '0,
  parameter int                     DUMP_WORDS  = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_halt,
  input  logic [ADDR_LENGTH-1:0] i_proc_Addr,
  input  logic [DATA_LENGTH-1:0] i_proc_Data,
  input  logic                   i_proc_Wr,
  input  logic                   i_proc_Rd,
  output logic [ADDR_LENGTH-1:0] o_ram_Addr,
  output logic [DATA_LENGTH-1:0] o_ram_Data,
  output logic                   o_ram_Wr,
  output logic                   o_ram_Rd,
  input  logic [DATA_LENGTH-1:0] i_ram_Data,
  output logic [7:0]             o_tx_Data,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  output logic                   o_busy,
  output logic                   o_done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_GRANT,
    S_READ,
    S_LATCH,
    S_SEND_LO,
    S_WAIT_LO,
    S_SEND_HI,
    S_WAIT_HI,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [ADDR_LENGTH-1:0] LAST_CNT = ADDR_LENGTH'(DUMP_WORDS - 1);

  state_t                   state_q, state_d;
  logic [ADDR_LENGTH-1:0]   addr_q, addr_d;
  logic [ADDR_LENGTH-1:0]   cnt_q, cnt_d;
  logic [DATA_LENGTH-1:0]   word_q, word_d;
  logic [7:0]               tx_data_q, tx_data_d;
  logic                     tx_start_q, tx_start_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (i_halt) state_d = S_GRANT;
      S_GRANT:   state_d = S_READ;
      S_READ:    state_d = S_LATCH;
      S_LATCH:   state_d = S_SEND_LO;
      S_SEND_LO: state_d = S_WAIT_LO;
      S_WAIT_LO: if (i_tx_done) state_d = S_SEND_HI;
      S_SEND_HI: state_d = S_WAIT_HI;
      S_WAIT_HI: if (i_tx_done) state_d = S_NEXT;
      S_NEXT:    state_d = (cnt_q == LAST_CNT) ? S_DONE : S_READ;
      // Halt must drop before a new dump can be armed.
      S_DONE:    if (!i_halt) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    word_d = word_q;
    case (state_q)
      S_IDLE: begin
        if (i_halt) begin
          addr_d = BASE_ADDR;
          cnt_d  = '0;
        end
      end
      S_LATCH: word_d = i_ram_Data;
      S_NEXT: begin
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Flags are registered from the next state so they change exactly with the state.
  always_comb begin
    tx_start_d = (state_d == S_SEND_LO) || (state_d == S_SEND_HI);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    tx_data_d  = tx_data_q;
    if (state_d == S_SEND_LO) begin
      tx_data_d = word_d[7:0];
    end else if (state_d == S_SEND_HI) begin
      tx_data_d = word_q[15:8];
    end

    if (state_q == S_IDLE) begin
      o_ram_Addr = i_proc_Addr;
      o_ram_Data = i_proc_Data;
      o_ram_Wr   = i_proc_Wr;
      o_ram_Rd   = i_proc_Rd;
    end else begin
      o_ram_Addr = addr_q;
      o_ram_Data = '0;
      o_ram_Wr   = 1'b0;
      o_ram_Rd   = (state_q == S_READ) || (state_q == S_LATCH);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      addr_q     <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_tx_Data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Bench for mem_dump_ctrl: two instances (base 0 / 16 words, base 0x7FE / 4 words) with RAM and UART models.
module tb_mem_dump_ctrl;
  localparam int AW = 11;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n     [2];
  logic          halt      [2];
  logic [AW-1:0] proc_addr [2];
  logic [DW-1:0] proc_dat  [2];
  logic          proc_wr   [2];
  logic          proc_rd   [2];
  logic [AW-1:0] ram_addr  [2];
  logic [DW-1:0] ram_wdat  [2];
  logic          ram_wr    [2];
  logic          ram_rd    [2];
  logic [DW-1:0] ram_rdat  [2];
  logic [7:0]    tx_dat    [2];
  logic          tx_start  [2];
  logic          tx_done   [2];
  logic          busy      [2];
  logic          done      [2];
  logic          inj_en    [2];

  logic [DW-1:0] mem   [2][2048];
  logic [3:0]    cnt   [2];
  logic          outst [2];
  logic          prev_rd [2];
  int            nb    [2];
  int            na    [2];
  int            viol  [2];
  logic [7:0]    got   [2][256];
  logic [AW-1:0] addrs [2][256];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_dump_ctrl #(
      .DATA_LENGTH (DW),
      .ADDR_LENGTH (AW),
      .BASE_ADDR   (g == 0 ? 11'h000 : 11'h7FE),
      .DUMP_WORDS  (g == 0 ? 16 : 4)
    ) u_dut (
      .i_clock     (clk),
      .i_reset     (rst_n[g]),
      .i_halt      (halt[g]),
      .i_proc_Addr (proc_addr[g]),
      .i_proc_Data (proc_dat[g]),
      .i_proc_Wr   (proc_wr[g]),
      .i_proc_Rd   (proc_rd[g]),
      .o_ram_Addr  (ram_addr[g]),
      .o_ram_Data  (ram_wdat[g]),
      .o_ram_Wr    (ram_wr[g]),
      .o_ram_Rd    (ram_rd[g]),
      .i_ram_Data  (ram_rdat[g]),
      .o_tx_Data   (tx_dat[g]),
      .o_tx_start  (tx_start[g]),
      .i_tx_done   (tx_done[g]),
      .o_busy      (busy[g]),
      .o_done      (done[g])
    );
  end

  // UART answers 10 cycles after each start; optional spurious pulses land in SEND_LO and READ.
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      tx_done[g] = (cnt[g] == 4'd1) |
                   (inj_en[g] & ((tx_start[g] & ~nb[g][0]) | (ram_rd[g] & ~prev_rd[g])));
    end
  end

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (ram_wr[g]) mem[g][ram_addr[g]] <= ram_wdat[g];
      if (ram_rd[g]) ram_rdat[g] <= mem[g][ram_addr[g]];
      if (!rst_n[g]) begin
        cnt[g]     <= 4'd0;
        outst[g]   <= 1'b0;
        prev_rd[g] <= 1'b0;
      end else begin
        prev_rd[g] <= ram_rd[g];
        if (ram_rd[g] && !prev_rd[g]) begin
          addrs[g][na[g][7:0]] <= ram_addr[g];
          na[g] <= na[g] + 1;
        end
        if (cnt[g] == 4'd1) outst[g] <= 1'b0;
        if (tx_start[g]) begin
          got[g][nb[g][7:0]] <= tx_dat[g];
          nb[g] <= nb[g] + 1;
          if (outst[g]) viol[g] <= viol[g] + 1;
          outst[g] <= 1'b1;
          cnt[g]   <= 4'd10;
        end else if (cnt[g] != 4'd0) begin
          cnt[g] <= cnt[g] - 4'd1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic raise_halt(input int g, input string tag);
    int k;
    @(negedge clk);
    halt[g] = 1'b1;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (tx_start[g]) break;
    end
    check(tag, k, 4);
  endtask

  task automatic wait_done(input int g, input int budget, input string tag);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done[g]) break;
    end
    check(tag, 32'(i < budget), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    logic [15:0] sh1 [4];
    int nb0, na1;

    for (int g = 0; g < 2; g++) begin
      rst_n[g] = 1'b0; halt[g] = 1'b0; inj_en[g] = 1'b0;
      proc_addr[g] = 11'h155; proc_dat[g] = '0; proc_wr[g] = 1'b0; proc_rd[g] = 1'b1;
    end
    for (int i = 0; i < 4; i++) sh1[i] = 16'($urandom);
    #12;
    for (int g = 0; g < 2; g++) begin
      check("rst_busy", busy[g], 0);
      check("rst_done", done[g], 0);
      check("rst_start", tx_start[g], 0);
      check("rst_txdat", tx_dat[g], 0);
      check("rst_pass_addr", ram_addr[g], 11'h155);
      check("rst_pass_rd", ram_rd[g], 1);
    end
    @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    proc_rd[0] = 1'b0; proc_rd[1] = 1'b0;

    @(negedge clk);
    proc_addr[0] = 11'h012; proc_wr[0] = 1'b1; proc_dat[0] = 16'hBEEF;
    #1;
    check("pass_addr", ram_addr[0], 11'h012);
    check("pass_wr", ram_wr[0], 1);
    check("pass_dat", ram_wdat[0], 16'hBEEF);
    check("pass_busy", busy[0], 0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      proc_addr[0] = 11'(i); proc_dat[0] = 16'h1100 + 16'(i); proc_wr[0] = 1'b1;
      if (i < 4) begin
        proc_addr[1] = 11'(11'h7FE + i); proc_dat[1] = sh1[i]; proc_wr[1] = 1'b1;
      end else begin
        proc_wr[1] = 1'b0;
      end
    end
    @(negedge clk);
    proc_wr[0] = 1'b0; proc_wr[1] = 1'b0;

    // Full dump on instance 0 while the processor keeps trying to write.
    nb0 = nb[0];
    raise_halt(0, "lat_first_start");
    proc_addr[0] = 11'd5; proc_dat[0] = 16'hDEAD; proc_wr[0] = 1'b1; proc_rd[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("own_wr", ram_wr[0], 0);
    check("own_dat", ram_wdat[0], 0);
    check("own_busy", busy[0], 1);
    wait_done(0, 1000, "done0_reached");
    check("nbytes0", nb[0] - nb0, 32);
    for (int i = 0; i < 32; i++) begin
      w = 16'h1100 + 16'(i / 2);
      check("byte0", got[0][8'(nb0 + i)], (i % 2) ? w[15:8] : w[7:0]);
    end
    check("viol0", viol[0], 0);
    check("ram5_kept", mem[0][5], 16'h1105);
    check("done0_flag", done[0], 1);
    proc_wr[0] = 1'b0; proc_addr[0] = 11'h012; proc_dat[0] = '0; proc_rd[0] = 1'b1;
    repeat (20) @(negedge clk);
    check("stay_done", done[0], 1);
    check("no_redump", nb[0] - nb0, 32);
    halt[0] = 1'b0;
    #1;
    check("done_owns_rd", ram_rd[0], 0);
    check("done_busy", busy[0], 1);
    @(negedge clk);
    check("idle_busy", busy[0], 0);
    check("idle_done", done[0], 0);
    check("idle_pass_addr", ram_addr[0], 11'h012);
    check("idle_pass_rd", ram_rd[0], 1);
    proc_rd[0] = 1'b0;

    // Instance 1: address wrap, spurious done pulses, halt dropped mid-dump.
    inj_en[1] = 1'b1;
    nb0 = nb[1]; na1 = na[1];
    raise_halt(1, "lat_wrap");
    @(negedge clk);
    halt[1] = 1'b0;
    wait_done(1, 1000, "done1_reached");
    check("nbytes1", nb[1] - nb0, 8);
    for (int i = 0; i < 8; i++) begin
      w = sh1[i / 2];
      check("byte1", got[1][8'(nb0 + i)], (i % 2) ? w[15:8] : w[7:0]);
    end
    for (int i = 0; i < 4; i++) check("wrap_addr", addrs[1][8'(na1 + i)], 11'(11'h7FE + i));
    check("viol1", viol[1], 0);
    @(negedge clk);
    check("idle1_busy", busy[1], 0);
    inj_en[1] = 1'b0;

    // Asynchronous reset in WAIT_HI of word 3, then a fresh dump.
    nb0 = nb[0];
    proc_addr[0] = 11'h0AB; proc_rd[0] = 1'b0; proc_wr[0] = 1'b0;
    @(negedge clk);
    halt[0] = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (nb[0] - nb0 >= 8) break;
    end
    check("reach_w3_hi", nb[0] - nb0, 8);
    #2;
    rst_n[0] = 1'b0; halt[0] = 1'b0;
    #1;
    check("arst_busy", busy[0], 0);
    check("arst_start", tx_start[0], 0);
    check("arst_txdat", tx_dat[0], 0);
    check("arst_done", done[0], 0);
    check("arst_pass_addr", ram_addr[0], 11'h0AB);
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    nb0 = nb[0];
    repeat (30) @(negedge clk);
    check("quiet_after_rst", nb[0] - nb0, 0);
    check("quiet_busy", busy[0], 0);
    raise_halt(0, "lat_restart");
    wait_done(0, 1000, "done_restart");
    check("nbytes_restart", nb[0] - nb0, 32);
    for (int i = 0; i < 32; i++) begin
      w = 16'h1100 + 16'(i / 2);
      check("byte_restart", got[0][8'(nb0 + i)], (i % 2) ? w[15:8] : w[7:0]);
    end
    check("viol_restart", viol[0], 0);
    halt[0] = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
